frame_decoder: RTL

FRAME_DECODER -- requirements
Module: frame_decoder

---
 rtl/frame_decoder_pkg.sv | 32 +++
 rtl/frame_decoder_byte_timer.sv | 29 ++
 rtl/frame_decoder.sv | 129 ++++++++++++
 3 files changed

// File: rtl/frame_decoder_pkg.sv
// Shared definitions for the command-frame decoder: FSM states, command codes
// and error codes.
package frame_decoder_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_GET_CMD,
    ST_GET_LH,
    ST_GET_LL,
    ST_GET_CHK,
    ST_ISSUE,
    ST_WAIT_BUSY,
    ST_WAIT_DONE,
    ST_RELEASE
  } state_t;

  localparam logic [7:0] CMD_NONE = 8'h00;
  localparam logic [7:0] CMD_SEND = 8'h01;
  localparam logic [7:0] CMD_INIT = 8'h02;
  localparam logic [7:0] CMD_RD   = 8'h03;
  localparam logic [7:0] CMD_WR   = 8'h04;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_CHK  = 2'd1;
  localparam logic [1:0] ERR_CMD  = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;

  function automatic logic cmd_is_valid(input logic [7:0] c);
    return (c >= CMD_SEND) && (c <= CMD_WR);
  endfunction

endpackage

// File: rtl/frame_decoder_byte_timer.sv
// Saturating inter-byte gap counter; o_expired stays high once the gap
// reaches TIMEOUT_CYC until the next clear.
module byte_timer #(
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  output logic o_expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (r_cnt != CNT_MAX) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_expired = (r_cnt == CNT_MAX);

endmodule

// File: rtl/frame_decoder.sv
// Parses HEADER/CMD/LEN_H/LEN_L/CHK frames from the UART byte stream and runs
// the command handshake with the FIFO controller.
module frame_decoder
  import frame_decoder_pkg::*;
#(
  parameter logic [7:0] HEADER      = 8'hA5,
  parameter int         TIMEOUT_CYC = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        fifo_busy,
  input  logic        fifo_done,
  output logic [7:0]  cmd,
  output logic [15:0] rx_cnt,
  output logic        fe_done,
  output logic        frame_err,
  output logic [1:0]  err_code
);

  state_t     r_state;
  logic [7:0] r_cmd_b;
  logic [7:0] r_lh;
  logic [7:0] r_ll;

  logic w_in_hdr;
  logic w_tmr_clear;
  logic w_tmo;

  assign w_in_hdr    = (r_state == ST_GET_CMD) || (r_state == ST_GET_LH) ||
                       (r_state == ST_GET_LL)  || (r_state == ST_GET_CHK);
  // Holding the timer clear in IDLE means GET_CMD always starts from zero.
  assign w_tmr_clear = rx_valid || (r_state == ST_IDLE);

  byte_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_byte_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (w_tmr_clear),
    .o_expired(w_tmo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cmd_b   <= '0;
      r_lh      <= '0;
      r_ll      <= '0;
      cmd       <= CMD_NONE;
      rx_cnt    <= '0;
      fe_done   <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      fe_done   <= 1'b0;
      frame_err <= 1'b0;
      // A byte arriving on the timeout cycle is consumed instead of faulting.
      if (w_in_hdr && !rx_valid && w_tmo) begin
        frame_err <= 1'b1;
        err_code  <= ERR_TMO;
        r_state   <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (rx_valid && (rx_data == HEADER)) r_state <= ST_GET_CMD;
          end
          ST_GET_CMD: begin
            if (rx_valid) begin
              r_cmd_b <= rx_data;
              r_state <= ST_GET_LH;
            end
          end
          ST_GET_LH: begin
            if (rx_valid) begin
              r_lh    <= rx_data;
              r_state <= ST_GET_LL;
            end
          end
          ST_GET_LL: begin
            if (rx_valid) begin
              r_ll    <= rx_data;
              r_state <= ST_GET_CHK;
            end
          end
          ST_GET_CHK: begin
            if (rx_valid) begin
              if (rx_data != (r_cmd_b ^ r_lh ^ r_ll)) begin
                frame_err <= 1'b1;
                err_code  <= ERR_CHK;
                r_state   <= ST_IDLE;
              end else if (!cmd_is_valid(r_cmd_b)) begin
                frame_err <= 1'b1;
                err_code  <= ERR_CMD;
                r_state   <= ST_IDLE;
              end else begin
                rx_cnt  <= {r_lh, r_ll};
                cmd     <= r_cmd_b;
                r_state <= ST_ISSUE;
              end
            end
          end
          ST_ISSUE: r_state <= ST_WAIT_BUSY;
          ST_WAIT_BUSY: begin
            if (fifo_busy) begin
              cmd     <= CMD_NONE;
              r_state <= ST_WAIT_DONE;
            end
          end
          ST_WAIT_DONE: begin
            if (fifo_done) begin
              fe_done <= 1'b1;
              r_state <= ST_RELEASE;
            end
          end
          ST_RELEASE: begin
            if (!fifo_busy) r_state <= ST_IDLE;
          end
          default: begin
            cmd     <= CMD_NONE;
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule
